// File: rtl/execute_stage_mc.sv
// EX pipeline stage: operand forwarding, ALU, branch resolution, iterative
// shift-add multiplier with stall/flush control, and the EX/MEM register.
module execute_stage_mc #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_to_reg_wr,
    input  logic                  reg_wr_en,
    input  logic                  mem_wr_en,
    input  logic                  alu_src_sel,
    input  logic                  branch,
    input  logic                  jump,
    input  logic                  is_mul,
    input  logic [2:0]            alu_ctrl,
    input  logic [1:0]            fwd_a_sel,
    input  logic [1:0]            fwd_b_sel,
    input  logic                  flush,
    input  logic                  mem_stall,
    input  logic [REG_ADDR_W-1:0] reg_wr_addr,
    input  logic [WIDTH-1:0]      pc_branch,
    input  logic [WIDTH-1:0]      pc_jump,
    input  logic [WIDTH-1:0]      reg_rd_data1,
    input  logic [WIDTH-1:0]      reg_rd_data2,
    input  logic [WIDTH-1:0]      sign_imm_ext,
    input  logic [WIDTH-1:0]      wb_result,
    input  logic [WIDTH-1:0]      mem_fwd_result,
    output logic                  ex_pc_src,
    output logic                  ex_jump,
    output logic [WIDTH-1:0]      ex_pc_branch,
    output logic [WIDTH-1:0]      ex_pc_jump,
    output logic                  ex_stall,
    output logic                  ex_mem_mem_to_reg_wr,
    output logic                  ex_mem_mem_wr_en,
    output logic                  ex_mem_reg_wr_en,
    output logic [REG_ADDR_W-1:0] ex_mem_reg_wr_addr,
    output logic [WIDTH-1:0]      ex_mem_alu_result,
    output logic [WIDTH-1:0]      ex_mem_mem_wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic                  mem_to_reg_q, mem_to_reg_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  reg_wr_en_q, reg_wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic [WIDTH-1:0]      wr_data_q, wr_data_d;

    logic [WIDTH-1:0] fwd_a_s, fwd_b_s, op_b_s, diff_s, alu_res_s;
    logic             mul_busy_s;

    // Forwarding muxes and B-operand immediate select
    always_comb begin
        case (fwd_a_sel)
            2'b01:   fwd_a_s = wb_result;
            2'b10:   fwd_a_s = mem_fwd_result;
            default: fwd_a_s = reg_rd_data1;
        endcase
        case (fwd_b_sel)
            2'b01:   fwd_b_s = wb_result;
            2'b10:   fwd_b_s = mem_fwd_result;
            default: fwd_b_s = reg_rd_data2;
        endcase
        if (alu_src_sel) begin
            op_b_s = sign_imm_ext;
        end else begin
            op_b_s = fwd_b_s;
        end
    end

    // ALU and branch/jump resolution toward fetch
    always_comb begin
        diff_s = fwd_a_s - op_b_s;
        case (alu_ctrl)
            3'b000:  alu_res_s = fwd_a_s & op_b_s;
            3'b001:  alu_res_s = fwd_a_s | op_b_s;
            3'b010:  alu_res_s = fwd_a_s + op_b_s;
            3'b110:  alu_res_s = diff_s;
            3'b111:  alu_res_s = {{(WIDTH-1){1'b0}},
                                  ($signed(fwd_a_s) < $signed(op_b_s))};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
        ex_pc_src    = branch & (diff_s == {WIDTH{1'b0}}) & ~flush;
        ex_jump      = jump;
        ex_pc_branch = pc_branch;
        ex_pc_jump   = pc_jump;
    end

    // Stall: multiply in progress (unless squashed) or downstream hold
    always_comb begin
        mul_busy_s = ((state_q == IDLE) & is_mul) | (state_q == RUN);
        ex_stall   = mem_stall | (mul_busy_s & ~flush);
    end

    // Multiplier next-state; flush aborts from any state
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (is_mul & ~flush) begin
                    mcand_d  = fwd_a_s;
                    mplier_d = op_b_s;
                    acc_d    = {WIDTH{1'b0}};
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                if (flush | ~mem_stall) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // EX/MEM next value: hold, bubble, or new result in priority order
    always_comb begin
        mem_to_reg_d = mem_to_reg_q;
        mem_wr_en_d  = mem_wr_en_q;
        reg_wr_en_d  = reg_wr_en_q;
        wr_addr_d    = wr_addr_q;
        result_d     = result_q;
        wr_data_d    = wr_data_q;
        if (mem_stall) begin
            mem_to_reg_d = mem_to_reg_q;
        end else if (flush | mul_busy_s) begin
            mem_to_reg_d = 1'b0;
            mem_wr_en_d  = 1'b0;
            reg_wr_en_d  = 1'b0;
            wr_addr_d    = {REG_ADDR_W{1'b0}};
            result_d     = {WIDTH{1'b0}};
            wr_data_d    = {WIDTH{1'b0}};
        end else begin
            mem_to_reg_d = mem_to_reg_wr;
            mem_wr_en_d  = mem_wr_en;
            reg_wr_en_d  = reg_wr_en;
            wr_addr_d    = reg_wr_addr;
            result_d     = (state_q == DONE) ? acc_q : alu_res_s;
            wr_data_d    = fwd_b_s;
        end
    end

    // Multiplier state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_to_reg_q <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            reg_wr_en_q  <= 1'b0;
            wr_addr_q    <= {REG_ADDR_W{1'b0}};
            result_q     <= {WIDTH{1'b0}};
            wr_data_q    <= {WIDTH{1'b0}};
        end else begin
            mem_to_reg_q <= mem_to_reg_d;
            mem_wr_en_q  <= mem_wr_en_d;
            reg_wr_en_q  <= reg_wr_en_d;
            wr_addr_q    <= wr_addr_d;
            result_q     <= result_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign ex_mem_mem_to_reg_wr = mem_to_reg_q;
    assign ex_mem_mem_wr_en     = mem_wr_en_q;
    assign ex_mem_reg_wr_en     = reg_wr_en_q;
    assign ex_mem_reg_wr_addr   = wr_addr_q;
    assign ex_mem_alu_result    = result_q;
    assign ex_mem_mem_wr_data   = wr_data_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc (WIDTH=32): ALU/forwarding, branch,
// multiply timing, flush abort, mem_stall hold and asynchronous reset.
module tb_execute_stage_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_to_reg_wr, reg_wr_en, mem_wr_en, alu_src_sel;
    logic         branch, jump, is_mul, flush, mem_stall;
    logic [2:0]   alu_ctrl;
    logic [1:0]   fwd_a_sel, fwd_b_sel;
    logic [4:0]   reg_wr_addr;
    logic [W-1:0] pc_branch, pc_jump, reg_rd_data1, reg_rd_data2;
    logic [W-1:0] sign_imm_ext, wb_result, mem_fwd_result;
    logic         ex_pc_src, ex_jump, ex_stall;
    logic [W-1:0] ex_pc_branch, ex_pc_jump;
    logic         ex_mem_mem_to_reg_wr, ex_mem_mem_wr_en, ex_mem_reg_wr_en;
    logic [4:0]   ex_mem_reg_wr_addr;
    logic [W-1:0] ex_mem_alu_result, ex_mem_mem_wr_data;

    int checks = 0;
    int errors = 0;
    int n;
    int bad;

    execute_stage_mc #(.WIDTH(W), .REG_ADDR_W(5), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .mem_to_reg_wr(mem_to_reg_wr), .reg_wr_en(reg_wr_en), .mem_wr_en(mem_wr_en),
        .alu_src_sel(alu_src_sel), .branch(branch), .jump(jump), .is_mul(is_mul),
        .alu_ctrl(alu_ctrl), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .flush(flush), .mem_stall(mem_stall), .reg_wr_addr(reg_wr_addr),
        .pc_branch(pc_branch), .pc_jump(pc_jump),
        .reg_rd_data1(reg_rd_data1), .reg_rd_data2(reg_rd_data2),
        .sign_imm_ext(sign_imm_ext), .wb_result(wb_result),
        .mem_fwd_result(mem_fwd_result),
        .ex_pc_src(ex_pc_src), .ex_jump(ex_jump),
        .ex_pc_branch(ex_pc_branch), .ex_pc_jump(ex_pc_jump),
        .ex_stall(ex_stall),
        .ex_mem_mem_to_reg_wr(ex_mem_mem_to_reg_wr),
        .ex_mem_mem_wr_en(ex_mem_mem_wr_en),
        .ex_mem_reg_wr_en(ex_mem_reg_wr_en),
        .ex_mem_reg_wr_addr(ex_mem_reg_wr_addr),
        .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_mem_wr_data(ex_mem_mem_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_to_reg_wr = 1'b0; reg_wr_en = 1'b0; mem_wr_en = 1'b0;
        alu_src_sel = 1'b0; branch = 1'b0; jump = 1'b0; is_mul = 1'b0;
        flush = 1'b0; mem_stall = 1'b0; alu_ctrl = 3'b000;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; reg_wr_addr = 5'd0;
        pc_branch = 32'h0; pc_jump = 32'h0; reg_rd_data1 = 32'h0;
        reg_rd_data2 = 32'h0; sign_imm_ext = 32'h0; wb_result = 32'h0;
        mem_fwd_result = 32'h0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #2;
        chk("rst_result", ex_mem_alu_result, 32'h0);
        chk("rst_regwr", {31'h0, ex_mem_reg_wr_en}, 32'h0);
        chk("rst_stall", {31'h0, ex_stall}, 32'h0);
        #10 reset = 1'b0;
        tick();

        // ADD: A forwarded from MEM (5) + B from register (7)
        alu_ctrl = 3'b010; fwd_a_sel = 2'b10; mem_fwd_result = 32'd5;
        reg_rd_data2 = 32'd7; reg_wr_en = 1'b1; reg_wr_addr = 5'd3;
        #1 chk("add_stall", {31'h0, ex_stall}, 32'h0);
        tick();
        chk("add_result", ex_mem_alu_result, 32'd12);
        chk("add_regwr", {31'h0, ex_mem_reg_wr_en}, 32'h1);
        chk("add_addr", {27'h0, ex_mem_reg_wr_addr}, 32'd3);
        chk("add_wdata", ex_mem_mem_wr_data, 32'd7);

        // SUB with immediate; store data is the forwarded B (wb_result)
        alu_ctrl = 3'b110; fwd_a_sel = 2'b00; reg_rd_data1 = 32'd20;
        alu_src_sel = 1'b1; sign_imm_ext = 32'd5; fwd_b_sel = 2'b01;
        wb_result = 32'd9; mem_wr_en = 1'b1; reg_wr_en = 1'b0;
        tick();
        chk("sub_result", ex_mem_alu_result, 32'd15);
        chk("sub_wdata", ex_mem_mem_wr_data, 32'd9);
        chk("sub_memwr", {31'h0, ex_mem_mem_wr_en}, 32'h1);

        // AND via fwd_a_sel=11 (register), then an undefined ALU code
        alu_ctrl = 3'b000; fwd_a_sel = 2'b11; reg_rd_data1 = 32'h0000_F0F0;
        alu_src_sel = 1'b0; fwd_b_sel = 2'b00; reg_rd_data2 = 32'h0000_FF00;
        mem_wr_en = 1'b0; reg_wr_en = 1'b1;
        tick();
        chk("and_result", ex_mem_alu_result, 32'h0000_F000);
        alu_ctrl = 3'b001;
        tick();
        chk("or_result", ex_mem_alu_result, 32'h0000_FFF0);
        alu_ctrl = 3'b011;
        tick();
        chk("undef_result", ex_mem_alu_result, 32'h0);

        // beq taken, then squashed by flush; jump pass-through unaffected
        alu_ctrl = 3'b110; fwd_a_sel = 2'b00; reg_rd_data1 = 32'h1234;
        reg_rd_data2 = 32'h1234; branch = 1'b1; reg_wr_en = 1'b0;
        jump = 1'b1; pc_jump = 32'h0040_0100; pc_branch = 32'h0040_0200;
        #1 chk("beq_taken", {31'h0, ex_pc_src}, 32'h1);
        reg_rd_data2 = 32'h1235;
        #1 chk("beq_not_taken", {31'h0, ex_pc_src}, 32'h0);
        reg_rd_data2 = 32'h1234;
        flush = 1'b1; reg_wr_en = 1'b1; mem_wr_en = 1'b1; mem_to_reg_wr = 1'b1;
        #1 chk("beq_flush", {31'h0, ex_pc_src}, 32'h0);
        chk("flush_jump", {31'h0, ex_jump}, 32'h1);
        chk("flush_pcj", ex_pc_jump, 32'h0040_0100);
        chk("flush_pcb", ex_pc_branch, 32'h0040_0200);
        tick();
        chk("flush_ctrl", {29'h0, ex_mem_mem_to_reg_wr, ex_mem_mem_wr_en, ex_mem_reg_wr_en}, 32'h0);
        idle_inputs();

        // MUL 0xFFFFFFFF * 3: 33 stall cycles of bubbles, then the product
        is_mul = 1'b1; reg_rd_data1 = 32'hFFFF_FFFF; reg_rd_data2 = 32'd3;
        reg_wr_en = 1'b1; reg_wr_addr = 5'd5;
        #1;
        n = 0; bad = 0;
        while (ex_stall && n < 100) begin
            n++;
            tick();
            if (ex_mem_reg_wr_en !== 1'b0) bad++;
        end
        chk("mul_stall_len", n, 32'd33);
        chk("mul_bubbles", bad, 32'd0);
        tick();
        chk("mul_result", ex_mem_alu_result, 32'hFFFF_FFFD);
        chk("mul_regwr", {31'h0, ex_mem_reg_wr_en}, 32'h1);
        chk("mul_addr", {27'h0, ex_mem_reg_wr_addr}, 32'd5);
        is_mul = 1'b0;

        // MUL 6*7 aborted by flush 10 cycles in; next ADD runs normally
        is_mul = 1'b1; reg_rd_data1 = 32'd6; reg_rd_data2 = 32'd7;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_pre_stall", {31'h0, ex_stall}, 32'h1);
        flush = 1'b1;
        #1 chk("abort_stall", {31'h0, ex_stall}, 32'h0);
        tick();
        chk("abort_regwr", {31'h0, ex_mem_reg_wr_en}, 32'h0);
        flush = 1'b0; is_mul = 1'b0; alu_ctrl = 3'b010;
        reg_rd_data1 = 32'd2; reg_rd_data2 = 32'd3;
        #1 chk("abort_idle", {31'h0, ex_stall}, 32'h0);
        tick();
        chk("abort_next_add", ex_mem_alu_result, 32'd5);
        chk("abort_next_regwr", {31'h0, ex_mem_reg_wr_en}, 32'h1);

        // MUL 6*7 held at DONE by mem_stall for 3 edges, then written once
        is_mul = 1'b1; reg_rd_data1 = 32'd6; reg_rd_data2 = 32'd7;
        for (int i = 0; i < 33; i++) tick();
        mem_stall = 1'b1;
        #1 chk("done_hold_stall", {31'h0, ex_stall}, 32'h1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ex_mem_reg_wr_en !== 1'b0 || ex_stall !== 1'b1) bad++;
        end
        chk("done_hold", bad, 32'd0);
        mem_stall = 1'b0;
        #1 chk("done_release_stall", {31'h0, ex_stall}, 32'h0);
        tick();
        chk("done_result", ex_mem_alu_result, 32'd42);
        chk("done_regwr", {31'h0, ex_mem_reg_wr_en}, 32'h1);
        is_mul = 1'b0; reg_wr_en = 1'b0; alu_ctrl = 3'b000;
        tick();
        chk("done_once", {31'h0, ex_mem_reg_wr_en}, 32'h0);

        // Load a real result, hold it with mem_stall while a MUL runs, reset mid-RUN
        alu_ctrl = 3'b010; reg_rd_data1 = 32'd10; reg_rd_data2 = 32'd20; reg_wr_en = 1'b1;
        tick();
        chk("pre_reset_add", ex_mem_alu_result, 32'd30);
        mem_stall = 1'b1; is_mul = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_reset_hold", ex_mem_alu_result, 32'd30);
        #2 reset = 1'b1; is_mul = 1'b0; mem_stall = 1'b0;
        #1;
        chk("async_rst_result", ex_mem_alu_result, 32'h0);
        chk("async_rst_ctrl", {29'h0, ex_mem_mem_to_reg_wr, ex_mem_mem_wr_en, ex_mem_reg_wr_en}, 32'h0);
        chk("async_rst_stall", {31'h0, ex_stall}, 32'h0);
        @(negedge clk) reset = 1'b0;

        // SLT is signed: -1 < 1 is 1, 1 < -1 is 0
        alu_ctrl = 3'b111; reg_rd_data1 = 32'hFFFF_FFFF; reg_rd_data2 = 32'd1;
        #1 chk("post_rst_stall", {31'h0, ex_stall}, 32'h0);
        tick();
        chk("slt_neg", ex_mem_alu_result, 32'd1);
        reg_rd_data1 = 32'd1; reg_rd_data2 = 32'hFFFF_FFFF;
        tick();
        chk("slt_pos", ex_mem_alu_result, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
- Parametrised next-generation EX pipeline stage for the MIPS core.
- Adds operand forwarding, stall and flush control, and an iterative shift-add multiplier that stalls the pipe while it runs.
- Sits between the ID/EX control/data outputs and the MEM stage, and owns the EX/MEM pipeline register.
- Branch and jump resolution stays combinational toward the fetch stage.

Parameters:
- WIDTH, 32: datapath width in bits; must be at least 4.
- REG_ADDR_W, 5: register-file address width.
- CNT_W, 6: multiplier iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mem_to_reg_wr  in  1  ID/EX control: write-back source is memory.
- reg_wr_en  in  1  ID/EX control: register write enable.
- mem_wr_en  in  1  ID/EX control: data-memory write enable.
- alu_src_sel  in  1  0 selects forwarded B; 1 selects sign_imm_ext.
- branch  in  1  beq instruction.
- jump  in  1  jump instruction.
- is_mul  in  1  multiply instruction; alu_ctrl is ignored when set.
- alu_ctrl  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed); other codes give 0.
- fwd_a_sel  in  2  00 reg_rd_data1, 01 wb_result, 10 mem_fwd_result, 11 reg_rd_data1.
- fwd_b_sel  in  2  same encoding, applied to reg_rd_data2.
- flush  in  1  squash the instruction currently in EX.
- mem_stall  in  1  downstream hold; EX/MEM must not advance.
- reg_wr_addr  in  REG_ADDR_W  destination register.
- pc_branch, pc_jump  in  WIDTH  precomputed targets.
- reg_rd_data1, reg_rd_data2, sign_imm_ext  in  WIDTH  operands.
- wb_result, mem_fwd_result  in  WIDTH  forwarding sources.
- ex_pc_src  out  1  branch taken.
- ex_jump  out  1  equals jump.
- ex_pc_branch, ex_pc_jump  out  WIDTH  pass-through targets.
- ex_stall  out  1  freeze IF/ID/EX.
- ex_mem_mem_to_reg_wr, ex_mem_mem_wr_en, ex_mem_reg_wr_en  out  1  registered control.
- ex_mem_reg_wr_addr  out  REG_ADDR_W  registered destination.
- ex_mem_alu_result, ex_mem_mem_wr_data  out  WIDTH  registered result and store data (forwarded B, before the immediate mux).

Behaviour:
- Reset: every ex_mem_* output is 0, the FSM is IDLE, and the counter and multiplier registers are 0. The combinational outputs follow their inputs.
- Operand A is the forwarded A value. Operand B is sign_imm_ext when alu_src_sel=1, otherwise the forwarded B value.
- ex_pc_src = branch & (A-B==0) & ~flush. It is combinational and is not gated by the FSM.
- Multiplier FSM, states IDLE / RUN / DONE:
  - IDLE, is_mul=1, flush=0: ex_stall=1. On the next edge, latch A (multiplicand) and B (multiplier), clear the accumulator, load count=WIDTH, go to RUN.
  - RUN: ex_stall=1. Each edge: if multiplier LSB=1, add the shifted multiplicand to the accumulator; shift the multiplicand left and the multiplier right; decrement count. On the edge where count=1, go to DONE.
  - DONE: ex_stall=mem_stall. On an edge with mem_stall=0, EX/MEM captures the low WIDTH bits of the product with the ID/EX controls, and the FSM returns to IDLE. With mem_stall=1 the FSM holds DONE.
  - The product is unsigned. Only the low WIDTH bits are kept (identical to a signed low product).
- Stall length: a multiply holds ex_stall high for WIDTH+1 cycles when mem_stall=0. The result appears on ex_mem_alu_result at the WIDTH+2-th edge after the multiply enters EX.
- While ex_stall=1 due to IDLE/RUN, EX/MEM loads a bubble at each edge: the three control bits are 0 and addr/data are don't-care (drive 0).
- EX/MEM update priority, highest first:
  1. reset.
  2. mem_stall=1: hold all of EX/MEM.
  3. flush=1: load a bubble.
  4. multiply busy: load a bubble.
  5. Otherwise load the ALU/mul result and the controls.
- mem_stall also forces ex_stall=1, so upstream stages hold with it.
- flush while in RUN or DONE aborts the multiply: FSM goes to IDLE on the next edge, a bubble is loaded, and ex_stall is 0 in the flush cycle.
- flush has no effect on jump/pc pass-through.
- SLT: signed compare of A and B; result 1 or 0, zero-extended to WIDTH.
- ADD and SUB wrap modulo 2^WIDTH. No overflow trap.
- Back-to-back multiplies: the second one starts from IDLE on the cycle after DONE retires.

Test Plan:
- ADD with fwd_a_sel=10, mem_fwd_result=5, reg_rd_data2=7, alu_src_sel=0 -> after 1 edge ex_mem_alu_result=12, ex_mem_reg_wr_en=1.
- beq with A=B=0x1234 and branch=1 -> ex_pc_src=1 in the same cycle; with flush=1 -> ex_pc_src=0 and EX/MEM controls 0 after the edge.
- WIDTH=32 MUL, A=0xFFFF_FFFF, B=3 -> ex_stall high for exactly 33 cycles, EX/MEM bubbles meanwhile, then ex_mem_alu_result=0xFFFF_FFFD with reg_wr_en=1.
- MUL 6*7 with flush asserted 10 cycles in -> ex_stall drops in that cycle, FSM IDLE, no write (reg_wr_en=0), next ADD executes normally.
- MUL 6*7 with mem_stall=1 held 3 cycles at DONE -> ex_stall stays high, result 42 is not written until mem_stall falls, then written exactly once.
- Assert reset mid-RUN (asynchronously, between edges) -> all ex_mem_* outputs 0 immediately, ex_stall=0 with is_mul=0; SLT A=-1, B=1 afterward -> result 1.
